// File: rtl/ram_selftest_if.sv
// Control, status, filler and RAM read signals of the RAM self-test sequencer.
// RAM_SELFTEST_TIMEOUT_EN adds the timeout status bit.
`timescale 1ns/1ps
interface ram_selftest_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int ERR_CNT_W = 8
);
    logic                 start;
    logic                 busy;
    logic                 ram_own;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ADDR_W-1:0]    first_err_addr;
    logic                 first_err_phase;
    logic                 fill_inc;
    logic                 fill_dec;
    logic                 fill_active;
    logic                 fill_done;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_W-1:0]    rd_data;
`ifdef RAM_SELFTEST_TIMEOUT_EN
    logic                 timeout;
`endif

    modport master (
        input  start,
        input  fill_active,
        input  fill_done,
        input  rd_data,
        output busy,
        output ram_own,
        output done,
        output pass,
        output err_cnt,
        output first_err_addr,
        output first_err_phase,
        output fill_inc,
        output fill_dec,
        output rd_en,
        output rd_addr
`ifdef RAM_SELFTEST_TIMEOUT_EN
        ,
        output timeout
`endif
    );

    modport slave (
        output start,
        output fill_active,
        output fill_done,
        output rd_data,
        input  busy,
        input  ram_own,
        input  done,
        input  pass,
        input  err_cnt,
        input  first_err_addr,
        input  first_err_phase,
        input  fill_inc,
        input  fill_dec,
        input  rd_en,
        input  rd_addr
`ifdef RAM_SELFTEST_TIMEOUT_EN
        ,
        input  timeout
`endif
    );
endinterface

// File: rtl/ram_selftest.sv
// RAM self-test: inc fill, read-back check, dec fill, read-back check, report.
// RAM_SELFTEST_TIMEOUT_EN bounds the fill-wait states by TIMEOUT cycles.
`timescale 1ns/1ps
module ram_selftest #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int RD_LAT    = 2,
    parameter int ERR_CNT_W = 8
`ifdef RAM_SELFTEST_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 256
`endif
) (
    input logic            clk,
    input logic            rst,
    ram_selftest_if.master bus
);
    localparam int N  = 1 << ADDR_W;
    localparam int CW = $clog2(N + RD_LAT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_INC,
        S_WAIT_INC,
        S_CHECK_INC,
        S_FILL_DEC,
        S_WAIT_DEC,
        S_CHECK_DEC,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic                 seen_q, seen_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 first_q, first_d;
    logic [ADDR_W-1:0]    faddr_q, faddr_d;
    logic                 fph_q, fph_d;
    logic                 pass_q, pass_d;

    logic [RD_LAT-1:0]    pv_q;
    logic [DATA_W-1:0]    pexp_q [RD_LAT];
    logic [ADDR_W-1:0]    paddr_q [RD_LAT];

    logic                 busy;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [ADDR_W-1:0]    pat;
    logic [DATA_W-1:0]    exp_w;
    logic                 is_chk;
    logic                 mism;

`ifdef RAM_SELFTEST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 timeout_q, timeout_d;
`endif

    assign is_chk  = (state_q == S_CHECK_INC) || (state_q == S_CHECK_DEC);
    assign rd_en   = is_chk && (cyc_q < CW'(N));
    assign rd_addr = cyc_q[ADDR_W-1:0];
    // dec pattern N-1-a in ADDR_W bits is the bitwise inverse of a
    assign pat     = (state_q == S_CHECK_DEC) ? ~rd_addr : rd_addr;
    assign exp_w   = DATA_W'(pat);
    assign mism    = pv_q[RD_LAT-1] &&
                     (bus.rd_data != pexp_q[RD_LAT-1]);
    assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);

    assign bus.busy            = busy;
    assign bus.ram_own         = busy;
    assign bus.done            = (state_q == S_FIN);
    assign bus.pass            = pass_q;
    assign bus.err_cnt         = err_q;
    assign bus.first_err_addr  = faddr_q;
    assign bus.first_err_phase = fph_q;
    assign bus.fill_inc        = (state_q == S_FILL_INC);
    assign bus.fill_dec        = (state_q == S_FILL_DEC);
    assign bus.rd_en           = rd_en;
    assign bus.rd_addr         = rd_addr;
`ifdef RAM_SELFTEST_TIMEOUT_EN
    assign bus.timeout         = timeout_q;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        seen_d  = seen_q;
        err_d   = err_q;
        first_d = first_q;
        faddr_d = faddr_q;
        fph_d   = fph_q;
        pass_d  = pass_q;
`ifdef RAM_SELFTEST_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
`endif

        if (mism) begin
            if (err_q != {ERR_CNT_W{1'b1}}) begin
                err_d = err_q + 1'b1;
            end
            if (!first_q) begin
                first_d = 1'b1;
                faddr_d = paddr_q[RD_LAT-1];
                fph_d   = (state_q == S_CHECK_DEC);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FILL_INC;
                    err_d   = '0;
                    first_d = 1'b0;
                    faddr_d = '0;
                    fph_d   = 1'b0;
                    pass_d  = 1'b0;
`ifdef RAM_SELFTEST_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_FILL_INC, S_FILL_DEC: begin
                state_d = (state_q == S_FILL_INC) ? S_WAIT_INC : S_WAIT_DEC;
                seen_d  = 1'b0;
`ifdef RAM_SELFTEST_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT_INC, S_WAIT_DEC: begin
                if (bus.fill_active) begin
                    seen_d = 1'b1;
                end
                if (seen_q && !bus.fill_active && bus.fill_done) begin
                    state_d = (state_q == S_WAIT_INC) ? S_CHECK_INC
                                                      : S_CHECK_DEC;
                    cyc_d   = '0;
                end
`ifdef RAM_SELFTEST_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d   = S_FIN;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_CHECK_INC, S_CHECK_DEC: begin
                cyc_d = cyc_q + 1'b1;
                // one cycle of slack after the last compare
                if (cyc_q == CW'(N + RD_LAT)) begin
                    if (state_q == S_CHECK_INC) begin
                        state_d = S_FILL_DEC;
                    end else begin
                        state_d = S_FIN;
`ifdef RAM_SELFTEST_TIMEOUT_EN
                        pass_d  = (err_d == '0) && !timeout_q;
`else
                        pass_d  = (err_d == '0);
`endif
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            seen_q  <= 1'b0;
            err_q   <= '0;
            first_q <= 1'b0;
            faddr_q <= '0;
            fph_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            first_q <= first_d;
            faddr_q <= faddr_d;
            fph_q   <= fph_d;
            pass_q  <= pass_d;
        end
    end

`ifdef RAM_SELFTEST_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    // expected word and address travel alongside the read strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pexp_q[i]  <= '0;
                paddr_q[i] <= '0;
            end
        end else begin
            pv_q[0]    <= rd_en;
            pexp_q[0]  <= exp_w;
            paddr_q[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_ram_selftest.sv
// Bench for ram_selftest: filler model, behavioural RAM, second DUT
// with a 2-bit error counter reading an all-zero RAM.
`timescale 1ns/1ps
module tb_ram_selftest;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int RL = 2;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_selftest_if #(.DATA_W(DW), .ADDR_W(AW), .ERR_CNT_W(8)) bus ();
    ram_selftest_if #(.DATA_W(DW), .ADDR_W(AW), .ERR_CNT_W(2)) sbus ();

    ram_selftest #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .ERR_CNT_W(8)
`ifdef RAM_SELFTEST_TIMEOUT_EN
        , .TIMEOUT(20)
`endif
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ram_selftest #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .ERR_CNT_W(2)
    ) u_sat (
        .clk(clk),
        .rst(rst),
        .bus(sbus)
    );

    logic hang = 1'b0;
    logic stuck5 = 1'b0;
    logic sat_en = 1'b0;
    logic pend, pend_ph, fph;
    int   fcnt;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] dq0, dq1;

    assign sbus.start       = bus.start & sat_en;
    assign sbus.fill_active = bus.fill_active;
    assign sbus.fill_done   = bus.fill_done;
    assign sbus.rd_data     = '0;
    assign bus.rd_data      = dq1;

    // filler model: starts one cycle late so a stale fill_done is visible
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fill_active <= 1'b0;
            bus.fill_done   <= 1'b0;
            pend            <= 1'b0;
            pend_ph         <= 1'b0;
            fph             <= 1'b0;
            fcnt            <= 0;
        end else begin
            pend    <= (bus.fill_inc | bus.fill_dec) & ~hang;
            pend_ph <= bus.fill_dec;
            if (pend) begin
                bus.fill_active <= 1'b1;
                bus.fill_done   <= 1'b0;
                fcnt            <= 0;
                fph             <= pend_ph;
            end else if (bus.fill_active) begin
                mem[fcnt] <= fph ? DW'(N - 1 - fcnt) : DW'(fcnt);
                if (fcnt == N - 1) begin
                    bus.fill_active <= 1'b0;
                    bus.fill_done   <= 1'b1;
                end else begin
                    fcnt <= fcnt + 1;
                end
            end
        end
    end

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = mem[a];
        if (stuck5 && a == 3'd5) w[0] = 1'b0;
        return w;
    endfunction

    always @(posedge clk) begin
        dq0 <= bus.rd_en ? rd_word(bus.rd_addr) : 16'hDEAD;
        dq1 <= dq0;
    end

    int cyc = 0;
    int n_finc = 0, n_fdec = 0, n_done = 0;
    int finc_cyc = 0, fdec_cyc = 0, done_cyc = 0;
    int q_addr[$];
    int rd_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.rd_en) begin
            q_addr.push_back(int'(bus.rd_addr));
            rd_cyc.push_back(cyc);
        end
        if (bus.fill_inc) begin n_finc++; finc_cyc = cyc; end
        if (bus.fill_dec) begin n_fdec++; fdec_cyc = cyc; end
        if (bus.done) begin n_done++; done_cyc = cyc; end
    end

    typedef struct {
        int cnt;
        int faddr;
        int fph;
        bit any;
    } res_t;

    // expected outcome of one run from the read-back rules
    function automatic res_t model(bit stuck, bit zeros, int maxc);
        res_t r;
        r = '{0, 0, 0, 1'b0};
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < N; a++) begin
                int e, g;
                e = ph ? (N - 1 - a) : a;
                g = zeros ? 0 : ((stuck && a == 5) ? (e & ~1) : e);
                if (g != e) begin
                    if (!r.any) begin
                        r.any = 1'b1; r.faddr = a; r.fph = ph;
                    end
                    if (r.cnt < maxc) r.cnt++;
                end
            end
        end
        return r;
    endfunction

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, bus.done, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        res_t r, rs;
        int b_rd, b_fi, b_fd, b_dn, bad, k;

        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_own", bus.ram_own, 0);
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_err", bus.err_cnt, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_fills", {bus.fill_inc, bus.fill_dec}, 0);
        rst = 1'b0;
        @(negedge clk);

        // clean run, saturation DUT in lockstep
        sat_en = 1'b1;
        b_rd = q_addr.size(); b_fi = n_finc; b_fd = n_fdec; b_dn = n_done;
        pulse_start();
        sat_en = 1'b0;
        check("start_to_fill_inc", bus.fill_inc, 1);
        check("busy_run", {bus.busy, bus.ram_own}, 3);
        wait_done("clean");
        r = model(1'b0, 1'b0, 255);
        rs = model(1'b0, 1'b1, 3);
        check("clean_pass", bus.pass, r.cnt == 0);
        check("clean_err", bus.err_cnt, r.cnt);
        check("done_busy", {bus.busy, bus.ram_own}, 0);
        check("sat_done", sbus.done, 1);
        check("sat_err", sbus.err_cnt, rs.cnt);
        check("sat_faddr", sbus.first_err_addr, rs.faddr);
        check("sat_fph", sbus.first_err_phase, rs.fph);
        check("sat_pass", sbus.pass, 0);
        repeat (4) @(negedge clk);
        check("clean_nreads", q_addr.size() - b_rd, 2 * N);
        bad = 0;
        for (int i = 0; i < 2 * N; i++) begin
            if (q_addr[b_rd + i] != i % N) bad++;
            if (rd_cyc[b_rd + i] != rd_cyc[b_rd] + (i % N) +
                (i / N) * (rd_cyc[b_rd + N] - rd_cyc[b_rd])) bad++;
        end
        check("rd_addr_seq", bad, 0);
        check("n_fill_inc", n_finc - b_fi, 1);
        check("n_fill_dec", n_fdec - b_fd, 1);
        check("n_done", n_done - b_dn, 1);
        check("inc_to_rd", rd_cyc[b_rd] - finc_cyc, 11);
        check("chk_inc_len", fdec_cyc - rd_cyc[b_rd + N - 1], RL + 2);
        check("chk_dec_len", done_cyc - rd_cyc[b_rd + 2*N - 1], RL + 2);
        check("pass_hold", bus.pass, 1);

        // stuck bit with ignored starts in WAIT_INC and CHECK_DEC
        stuck5 = 1'b1;
        b_fi = n_finc; b_fd = n_fdec;
        pulse_start();
        k = 0;
        while (!bus.fill_active && k < 50) begin @(negedge clk); k++; end
        check("wait_inc_reached", bus.fill_active, 1);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        k = 0;
        while (!(bus.rd_en && n_fdec > b_fd) && k < 100) begin
            @(negedge clk); k++;
        end
        check("check_dec_reached", bus.rd_en, 1);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        wait_done("stuck");
        r = model(1'b1, 1'b0, 255);
        check("stuck_err", bus.err_cnt, r.cnt);
        check("stuck_faddr", bus.first_err_addr, r.faddr);
        check("stuck_fph", bus.first_err_phase, r.fph);
        check("stuck_pass", bus.pass, r.cnt == 0);
        check("ign_fill_inc", n_finc - b_fi, 1);
        check("ign_fill_dec", n_fdec - b_fd, 1);

        // start in the IDLE cycle after done
        stuck5 = 1'b0;
        @(negedge clk);
        check("idle_pass_hold", bus.pass, 0);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("restart_fill_inc", bus.fill_inc, 1);
        check("restart_err_clr", bus.err_cnt, 0);
        wait_done("rerun");
        check("rerun_pass", bus.pass, 1);
        check("rerun_err", bus.err_cnt, 0);

        // asynchronous reset mid read-back
        repeat (2) @(negedge clk);
        pulse_start();
        k = 0;
        while (!(bus.rd_en && bus.rd_addr == 3'd3) && k < 100) begin
            @(negedge clk); k++;
        end
        check("rd3_reached", bus.rd_en && bus.rd_addr == 3'd3, 1);
        b_dn = n_done;
        rst = 1'b1;
        #1;
        check("rst_async_out", {bus.rd_en, bus.busy, bus.ram_own}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done", n_done - b_dn, 0);
        pulse_start();
        wait_done("post_rst");
        check("post_rst_pass", bus.pass, 1);
        check("post_rst_err", bus.err_cnt, 0);

`ifdef RAM_SELFTEST_TIMEOUT_EN
        // filler that never responds
        repeat (2) @(negedge clk);
        hang = 1'b1;
        b_rd = q_addr.size(); b_fd = n_fdec;
        pulse_start();
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("tmo_latency", k, 21);
        check("tmo_flag", bus.timeout, 1);
        check("tmo_pass", bus.pass, 0);
        check("tmo_no_rd", q_addr.size() - b_rd, 0);
        check("tmo_no_dec", n_fdec - b_fd, 0);
        hang = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("tmo_clr", bus.timeout, 0);
        wait_done("tmo_rerun");
        check("tmo_rerun_pass", bus.pass, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
